// File: rtl/sc_pkg.sv
// Shared constants, state encoding and helpers for the stochastic stream encoder.
package sc_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned FRAME_LEN = 255;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;

  typedef enum logic {
    IDLE,
    RUN
  } enc_state_t;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned k);
    logic [15:0] d;
    d = {v, v} << (k % 8);
    return d[15:8];
  endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR with synchronous load and step enable.
module sc_lfsr8
  import sc_pkg::*;
#(
  parameter logic [7:0] RESET_VAL = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       enable,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_VAL;
    end else if (load) begin
      state <= seed;
    end else if (enable) begin
      state <= {state[6:0], ^(state & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/sc_stream_encoder.sv
// Converts a frame of N 8-bit pixels into N stochastic bitstreams of 255 bits,
// where channel i carries exactly pix[i] ones per frame.
module sc_stream_encoder
  import sc_pkg::*;
#(
  parameter int unsigned N    = 64,
  parameter int unsigned W    = 8,
  parameter logic [7:0]  SEED = 8'hA5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_valid,
  input  logic [N*W-1:0] pix_data,
  output logic           pix_ready,
  input  logic           stall,
  input  logic           abort,
  output logic [N-1:0]   stream,
  output logic           stream_valid,
  output logic           stream_last
);

  enc_state_t     state;
  logic [7:0]     cnt;
  logic [N*W-1:0] pix_reg;
  logic [7:0]     lfsr;
  logic [N-1:0]   cmp;
  logic           lfsr_load;
  logic           lfsr_step;

  assign pix_ready = (state == IDLE);
  assign lfsr_load = pix_valid && pix_ready;
  assign lfsr_step = (state == RUN) && !stall && !abort;

  sc_lfsr8 #(
    .RESET_VAL(SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .enable(lfsr_step),
    .seed  (SEED),
    .state (lfsr)
  );

  // Each channel sees a different rotation so adjacent channels decorrelate,
  // while every rotation still sweeps 1..255 exactly once per frame.
  always_comb begin
    cmp = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cmp[i] = (rotl8(lfsr, i % 8) <= pix_reg[i*W +: W]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pix_reg      <= '0;
      stream       <= '0;
      stream_valid <= 1'b0;
      stream_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stream_valid <= 1'b0;
          stream_last  <= 1'b0;
          if (pix_valid) begin
            pix_reg <= pix_data;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state        <= IDLE;
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
          end else if (stall) begin
            stream_valid <= 1'b0;
            stream_last  <= 1'b0;
          end else begin
            stream       <= cmp;
            stream_valid <= 1'b1;
            stream_last  <= (cnt == 8'(FRAME_LEN - 1));
            cnt          <= cnt + 8'd1;
            if (cnt == 8'(FRAME_LEN - 1)) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_stream_encoder.sv
// Directed bench for sc_stream_encoder: frame table plus abort, held-valid,
// mid-frame reset and random-frame sequences, checked against an LFSR model.
module tb_sc_stream_encoder;

  localparam int         N    = 64;
  localparam logic [7:0] SEED = 8'hA5;

  logic           clk = 1'b0;
  logic           reset;
  logic           pix_valid;
  logic [N*8-1:0] pix_data;
  logic           pix_ready;
  logic           stall;
  logic           abort;
  logic [N-1:0]   stream;
  logic           stream_valid;
  logic           stream_last;

  int checks = 0;
  int fails  = 0;

  logic [N-1:0] ref_seq[255];
  logic [N-1:0] cur_seq[255];

  typedef struct {
    logic [N*8-1:0] pix;
    int             stall_after;
    int             stall_len;
    int             exp_valid;
    logic           same_as_ref;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  sc_stream_encoder #(
    .N   (N),
    .W   (8),
    .SEED(SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .stall       (stall),
    .abort       (abort),
    .stream      (stream),
    .stream_valid(stream_valid),
    .stream_last (stream_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  function automatic logic [N-1:0] predict(input logic [7:0] l, input logic [N*8-1:0] p);
    logic [N-1:0] b;
    logic [7:0]   r;
    int           k;
    for (int i = 0; i < N; i++) begin
      k = i % 8;
      r = (l << k) | (l >> (8 - k));
      b[i] = (r <= p[i*8 +: 8]);
    end
    return b;
  endfunction

  // Offers pix, then follows the frame to its end (or to an abort/reset point).
  task automatic run_frame(input logic [N*8-1:0] pix, input logic [N*8-1:0] during_pix,
                           input logic hold, input int stall_after, input int stall_len,
                           input int abort_after, input int reset_after, output int nvalid);
    logic [7:0]   m;
    int           ones[N];
    int           gap;
    int           cyc;
    logic         done;
    logic         cut;
    logic [N-1:0] prev;
    m = SEED; nvalid = 0; gap = 0; cyc = 0; done = 0; cut = 0; prev = '0;
    for (int i = 0; i < N; i++) ones[i] = 0;
    pix_valid = 1'b1;
    pix_data  = pix;
    check("ready_before_accept", 64'(pix_ready), 64'd1);
    step;
    pix_valid = hold;
    pix_data  = during_pix;
    check("valid_low_on_accept_edge", 64'(stream_valid), 64'd0);
    check("busy_after_accept", 64'(pix_ready), 64'd0);
    step;
    check("first_valid_latency", 64'(stream_valid), 64'd1);
    while (!done && cyc < 1000) begin
      if (stream_valid) begin
        nvalid++;
        check("stream_bits", 64'(stream), 64'(predict(m, pix)));
        m = lfsr_next(m);
        check("stream_last", 64'(stream_last), 64'(nvalid == 255));
        for (int i = 0; i < N; i++) ones[i] += int'(stream[i]);
        if (nvalid <= 255) cur_seq[nvalid-1] = stream;
        prev = stream;
        if (nvalid >= 255) done = 1;
      end else begin
        gap++;
        check("stream_held_when_invalid", 64'(stream), 64'(prev));
        check("last_low_when_invalid", 64'(stream_last), 64'd0);
      end
      if (!done) begin
        stall = (nvalid == stall_after) && (gap < stall_len);
        if (nvalid == abort_after) begin
          abort = 1'b1; stall = 1'b1;
          step;
          abort = 1'b0; stall = 1'b0;
          check("abort_valid_low", 64'(stream_valid), 64'd0);
          check("abort_ready_high", 64'(pix_ready), 64'd1);
          check("abort_no_last", 64'(stream_last), 64'd0);
          done = 1; cut = 1;
        end else if (nvalid == reset_after) begin
          reset = 1'b1;
          #1;
          check("reset_stream_zero", 64'(stream), 64'd0);
          check("reset_valid_zero", 64'(stream_valid), 64'd0);
          check("reset_last_zero", 64'(stream_last), 64'd0);
          repeat (3) @(posedge clk);
          #1;
          reset = 1'b0;
          repeat (3) begin
            step;
            check("post_reset_valid_zero", 64'(stream_valid), 64'd0);
            check("post_reset_stream_zero", 64'(stream), 64'd0);
            check("post_reset_ready", 64'(pix_ready), 64'd1);
          end
          done = 1; cut = 1;
        end else begin
          step;
          cyc++;
        end
      end
    end
    stall = 1'b0;
    abort = 1'b0;
    if (!done) check("frame_timeout", 64'd0, 64'd1);
    if (!cut) begin
      check("valid_count", 64'(nvalid), 64'd255);
      check("stall_gap_cycles", 64'(gap), 64'(stall_after >= 0 ? stall_len : 0));
      check("ready_after_last", 64'(pix_ready), 64'd1);
      for (int i = 0; i < N; i++)
        check($sformatf("ones_ch%0d", i), 64'(ones[i]), 64'(pix[i*8 +: 8]));
    end
  endtask

  initial begin
    logic [N*8-1:0] base, ramp, alt, rnd;
    int             nv;

    base = '0;
    base[5*8 +: 8]  = 8'd128;
    base[63*8 +: 8] = 8'd255;
    for (int i = 0; i < N; i++) begin
      ramp[i*8 +: 8] = 8'(i * 4 + 3);
      alt[i*8 +: 8]  = (i % 2 == 0) ? 8'd0 : 8'd255;
    end
    vecs[0] = '{base, -1, 0, 255, 1'b0};
    vecs[1] = '{base, 100, 10, 255, 1'b1};
    vecs[2] = '{{N{8'h80}}, -1, 0, 255, 1'b0};
    vecs[3] = '{ramp, 1, 1, 255, 1'b0};
    vecs[4] = '{alt, 254, 3, 255, 1'b0};

    reset = 1'b1; pix_valid = 1'b0; pix_data = '0; stall = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stream", 64'(stream), 64'd0);
    check("reset_valid", 64'(stream_valid), 64'd0);
    check("reset_last", 64'(stream_last), 64'd0);
    reset = 1'b0;
    step;
    check("ready_after_reset", 64'(pix_ready), 64'd1);

    // stall/abort in IDLE do nothing
    stall = 1'b1; abort = 1'b1;
    step;
    check("idle_stall_abort_ready", 64'(pix_ready), 64'd1);
    check("idle_stall_abort_valid", 64'(stream_valid), 64'd0);
    stall = 1'b0; abort = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].pix, '0, 1'b0, vecs[v].stall_after, vecs[v].stall_len, -1, -1, nv);
      check("table_valid_count", 64'(nv), 64'(vecs[v].exp_valid));
      if (v == 0) ref_seq = cur_seq;
      if (vecs[v].same_as_ref) check("stalled_seq_matches", 64'(cur_seq == ref_seq), 64'd1);
      step;
    end

    // abort together with stall after the 50th bit, then a full frame
    run_frame(base, '0, 1'b0, -1, 0, 50, -1, nv);
    run_frame(ramp, '0, 1'b0, -1, 0, -1, -1, nv);
    step;

    // pix_valid held high across two frames; data changes during RUN
    run_frame({N{8'd200}}, {N{8'd17}}, 1'b1, -1, 0, -1, -1, nv);
    run_frame({N{8'd17}}, '0, 1'b0, -1, 0, -1, -1, nv);
    step;

    // reset mid-frame, then the first frame must repeat bit for bit
    run_frame(base, '0, 1'b0, -1, 0, -1, 30, nv);
    run_frame(base, '0, 1'b0, -1, 0, -1, -1, nv);
    check("post_reset_seq_matches", 64'(cur_seq == ref_seq), 64'd1);
    step;

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) rnd[i*8 +: 8] = 8'($urandom_range(0, 255));
      run_frame(rnd, '0, 1'b0, -1, 0, -1, -1, nv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sc_stream_encoder.md
SC_STREAM_ENCODER -- requirements
Module: sc_stream_encoder

Interface
REQ-001 Parameter N, default 64, number of pixel channels (one output stream bit per channel per cycle).
REQ-002 Parameter W, default 8, pixel precision; fixed at 8 (LFSR width).
REQ-003 Parameter SEED, default 8'hA5, LFSR load value; nonzero.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pix_valid  input  1  a pixel frame is offered on pix_data.
REQ-007 pix_data  input  N*W  packed unsigned pixels; channel i is bits [i*W +: W].
REQ-008 pix_ready  output  1  the encoder accepts a frame this cycle.
REQ-009 stall  input  1  freezes stream generation for this cycle.
REQ-010 abort  input  1  synchronous frame cancel.
REQ-011 stream  output  N  one stochastic bit per channel; drives a network's din.
REQ-012 stream_valid  output  1  stream carries a frame bit this cycle.
REQ-013 stream_last  output  1  final (255th) bit of the frame.

Function
REQ-014 FSM states are IDLE and RUN; pix_ready SHALL equal (state==IDLE), combinationally.
REQ-015 Edge with pix_valid&&pix_ready: capture pix_data into pix_reg, set lfsr to SEED, set cnt to 0, and move to RUN.
REQ-016 In IDLE, stall has no effect and abort has no effect.
REQ-017 The LFSR is 8-bit Fibonacci with polynomial x^8+x^6+x^5+x^4+1, shifting left with the feedback bit entering at bit 0; its period SHALL be 255.
REQ-018 Per-channel random value: r_i = lfsr rotated left by (i mod 8).
REQ-019 RUN, non-stalled edge:
- stream[i] <= (r_i <= pix_reg[i]);
- stream_valid <= 1;
- stream_last <= (cnt==254);
- lfsr advances one step;
- cnt <= cnt+1.
REQ-020 RUN edge with cnt==254 (and no stall or abort): state <= IDLE.
REQ-021 RUN, stalled edge: stream_valid <= 0, stream_last <= 0; lfsr, cnt, pix_reg, stream and state hold.
REQ-022 Abort edge in RUN: state <= IDLE, stream_valid <= 0, stream_last <= 0; abort has priority over stall and over the last-bit update.
REQ-023 Edge in IDLE: stream_valid <= 0 and stream_last <= 0, including the accepting edge.
REQ-024 Latency: first stream_valid appears the cycle after the first RUN edge, i.e. 2 cycles after acceptance; each frame delivers exactly 255 valid bits.
REQ-025 Exactness: over one unaborted frame, channel i SHALL carry exactly pix_reg[i] ones (0 gives all zeros; 255 gives all ones).
REQ-026 pix_valid during RUN is ignored, and pix_reg is not modified.
REQ-027 Back-to-back frames: a frame can be accepted the cycle after stream_last; stream_valid is low on exactly one cycle between frames.
REQ-028 cnt is 8 bits wide, counts 0..254, and never wraps.

Reset
REQ-029 On reset assertion, asynchronously:
- state=IDLE, lfsr=SEED, cnt=0, pix_reg=0;
- stream=0, stream_valid=0, stream_last=0;
- pix_ready=1 once reset is released.
REQ-030 Reset during RUN discards the frame; no further valid bits are produced.

Structure
REQ-031 Shared package sc_pkg SHALL hold:
- the pixel-width constant (8);
- the frame-length constant (255);
- the LFSR tap mask;
- the encoder state enum.
REQ-032 A single sub-module, sc_lfsr8 (load, enable, seed input, 8-bit state output), SHALL implement the LFSR; comparators and the FSM stay in sc_stream_encoder.

Verification
REQ-033 Frame with all pixels 0, pixel 5 = 128, pixel 63 = 255, no stall -> 255 valid cycles; ones counts 0/128/255; stream_last on the 255th valid bit only.
REQ-034 Same frame, stall held for 10 cycles after the 100th valid bit -> identical bit sequence and counts; stream_valid low for exactly those 10 cycles.
REQ-035 Abort asserted together with stall after the 50th valid bit -> stream_valid low on the next cycle, pix_ready high, no stream_last; a new frame then produces full counts.
REQ-036 pix_valid held high continuously with two frames (all pixels 200, then all 17) -> second frame's data is not captured during RUN; exactly one invalid gap cycle; counts 200 then 17.
REQ-037 Reset asserted mid-frame (after the 30th valid bit), released 3 cycles later -> outputs 0 immediately on assertion, and 0 until a new frame is accepted; lfsr restarts from SEED (the first-frame bits repeat).
REQ-038 Random pixel values, 20 frames -> every channel's ones count equals its pixel value exactly.
